// File: rtl/wb_fpmul_bridge.sv
// Wishbone register front-end for the pad-side FP multiplier: serialises two fp32
// operands onto the 23-bit operand bus and gathers the product from the 12-bit result bus.
module wb_fpmul_bridge #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [22:0] op_bus_o,
    input  logic [11:0] res_bus_i,
    output logic        busy_o,
    output logic        done_irq_o
);

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  chunk_q, chunk_d;
    logic [1:0]  exp_idx_q, exp_idx_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // A seen access is latched and serviced during its single ack cycle.
    logic        ack_q, ack_d;
    logic        req_we_q;
    logic [2:0]  req_off_q;
    logic [3:0]  req_sel_q;
    logic [31:0] req_dat_q;

    logic        access;
    logic        busy;
    logic        wr_en;
    logic        rd_en;
    logic        go;
    logic        res_valid;
    logic [1:0]  res_idx;
    logic [7:0]  res_byte;
    logic [31:0] opa_merge;
    logic [31:0] opb_merge;
    logic [31:0] result_store;
    logic [15:0] chunk_data;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign access    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    assign ack_d     = access & ~ack_q;
    assign busy      = (state_q == S_SEND) || (state_q == S_START) || (state_q == S_WAIT);
    assign wr_en     = ack_q & req_we_q & ~busy;
    assign rd_en     = ack_q & ~req_we_q;
    assign go        = wr_en && (state_q == S_IDLE) && (req_off_q == 3'd2)
                       && req_sel_q[0] && req_dat_q[0];
    assign res_valid = res_bus_i[10];
    assign res_idx   = res_bus_i[9:8];
    assign res_byte  = res_bus_i[7:0];
    assign unused_ok = ^{res_bus_i[11], wbs_adr_i[1:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign opa_merge[8*gi +: 8]    = req_sel_q[gi] ? req_dat_q[8*gi +: 8] : opa_q[8*gi +: 8];
            assign opb_merge[8*gi +: 8]    = req_sel_q[gi] ? req_dat_q[8*gi +: 8] : opb_q[8*gi +: 8];
            assign result_store[8*gi +: 8] = (exp_idx_q == 2'(gi)) ? res_byte : result_q[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            req_we_q  <= 1'b0;
            req_off_q <= 3'd0;
            req_sel_q <= 4'd0;
            req_dat_q <= 32'd0;
            state_q   <= S_IDLE;
            chunk_q   <= 2'd0;
            exp_idx_q <= 2'd0;
            tmo_q     <= 8'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= ack_d;
            if (ack_d) begin
                req_we_q  <= wbs_we_i;
                req_off_q <= wbs_adr_i[4:2];
                req_sel_q <= wbs_sel_i;
                req_dat_q <= wbs_dat_i;
            end
            state_q   <= state_d;
            chunk_q   <= chunk_d;
            exp_idx_q <= exp_idx_d;
            tmo_q     <= tmo_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        exp_idx_d = exp_idx_q;
        tmo_d     = tmo_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        done_d    = done_q;
        err_d     = err_q;

        if (wr_en && (req_off_q == 3'd0)) opa_d = opa_merge;
        if (wr_en && (req_off_q == 3'd1)) opb_d = opb_merge;
        if (rd_en && (req_off_q == 3'd4) && !busy) done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_SEND;
                    chunk_d  = 2'd0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    result_d = 32'd0;
                end
            end
            S_SEND: begin
                chunk_d = chunk_q + 2'd1;
                if (chunk_q == 2'd3) state_d = S_START;
            end
            S_START: begin
                tmo_d     = TMO_LOAD;
                exp_idx_d = 2'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid) begin
                    if (res_idx == exp_idx_q) begin
                        result_d = result_store;
                        tmo_d    = TMO_LOAD;
                        if (exp_idx_q == 2'd3) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            exp_idx_d = exp_idx_q + 2'd1;
                        end
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else if (tmo_q <= 8'd1) begin
                    // The decrement that would land on zero is the abort point.
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (chunk_q)
            2'd0:    chunk_data = opa_q[15:0];
            2'd1:    chunk_data = opa_q[31:16];
            2'd2:    chunk_data = opb_q[15:0];
            default: chunk_data = opb_q[31:16];
        endcase
    end

    always_comb begin
        op_bus_o = 23'd0;
        if (state_q == S_SEND) begin
            op_bus_o[18]    = 1'b1;
            op_bus_o[17:16] = chunk_q;
            op_bus_o[15:0]  = chunk_data;
        end else if (state_q == S_START) begin
            op_bus_o[19] = 1'b1;
        end
    end

    always_comb begin
        case (req_off_q)
            3'd0:    rd_data = opa_q;
            3'd1:    rd_data = opb_q;
            3'd3:    rd_data = {29'd0, err_q, done_q, busy};
            3'd4:    rd_data = result_q;
            default: rd_data = 32'd0;
        endcase
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rd_en ? rd_data : 32'd0;
    assign busy_o     = busy;
    assign done_irq_o = (state_q == S_DONE) || (state_q == S_ERR);

endmodule

// File: tb/tb_wb_fpmul_bridge.sv
// Directed bench for wb_fpmul_bridge: register access, operand serialisation,
// result collection, timeout/index errors, busy write blocking and reset.
module tb_wb_fpmul_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        srst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] dat_o;
    logic [22:0] op_bus;
    logic [11:0] res_bus;
    logic        busy, irq;

    int total = 0;
    int bad   = 0;

    wb_fpmul_bridge dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (srst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .op_bus_o   (op_bus),
        .res_bus_i  (res_bus),
        .busy_o     (busy),
        .done_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Classic single access; returns one idle cycle after the ack cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdata, output logic acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        acked = 1'b0;
        rdata = 32'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack) begin
                acked = 1'b1;
                rdata = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic wr(input string tag, input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic a;
        xfer(1'b1, BASE + {27'd0, off, 2'b00}, d, s, r, a);
        chk({tag, "_ack"}, {31'd0, a}, 32'd1);
        $display("wr  off=%0d data=%h sel=%b ack=%0d", off, d, s, a);
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] r;
        logic a;
        xfer(1'b0, BASE + {27'd0, off, 2'b00}, 32'd0, 4'hF, r, a);
        chk({tag, "_ack"}, {31'd0, a}, 32'd1);
        chk(tag, r, exp);
        $display("rd  off=%0d data=%h ack=%0d", off, r, a);
    endtask

    function automatic logic [31:0] chunk_word(input logic [1:0] k, input logic [15:0] d);
        return {9'd0, 1'b0, 1'b1, k, d};
    endfunction

    // Writes both operands and GO, then checks the 4 chunks and the start cycle.
    task automatic go_and_chunks(input logic [31:0] a, input logic [31:0] b);
        wr("opa", 3'd0, a, 4'hF);
        wr("opb", 3'd1, b, 4'hF);
        wr("go", 3'd2, 32'd1, 4'hF);
        chk("chunk0", {9'd0, op_bus}, chunk_word(2'd0, a[15:0]));
        tick();
        chk("chunk1", {9'd0, op_bus}, chunk_word(2'd1, a[31:16]));
        tick();
        chk("chunk2", {9'd0, op_bus}, chunk_word(2'd2, b[15:0]));
        tick();
        chk("chunk3", {9'd0, op_bus}, chunk_word(2'd3, b[31:16]));
        tick();
        chk("start", {9'd0, op_bus}, 32'h0008_0000);
        $display("sent opa=%h opb=%h", a, b);
    endtask

    // Called in WAIT; presents four in-order bytes and checks the done pulse.
    task automatic feed(input logic [31:0] prod);
        for (int i = 0; i < 4; i++) begin
            res_bus = {1'b0, 1'b1, 2'(i), prod[8*i +: 8]};
            tick();
        end
        res_bus = 12'd0;
        chk("irq_on", {31'd0, irq}, 32'd1);
        chk("busy_off", {31'd0, busy}, 32'd0);
        tick();
        chk("irq_off", {31'd0, irq}, 32'd0);
        $display("fed product=%h", prod);
    endtask

    initial begin
        logic [31:0] r;
        logic a;
        srst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'd0; dat = 32'd0; res_bus = 12'd0;
        repeat (3) tick();
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_op", {9'd0, op_bus}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        srst = 1'b0;
        tick();
        rd("rst_status", 3'd3, 32'd0);
        rd("rst_result", 3'd4, 32'd0);
        rd("rst_opa", 3'd0, 32'd0);

        // Unmapped offsets and foreign addresses
        wr("off5_wr", 3'd5, 32'hFFFF_FFFF, 4'hF);
        rd("off5_rd", 3'd5, 32'd0);
        rd("ctrl_rd", 3'd2, 32'd0);
        xfer(1'b0, 32'h3000_0020, 32'd0, 4'hF, r, a);
        chk("nomatch_ack", {31'd0, a}, 32'd0);
        $display("rd  adr=30000020 ack=%0d", a);

        // 1.5 * 2.0 = 3.0
        go_and_chunks(32'h3FC0_0000, 32'h4000_0000);
        tick();
        chk("wait_busy", {31'd0, busy}, 32'd1);
        chk("wait_op", {9'd0, op_bus}, 32'd0);
        feed(32'h4040_0000);
        rd("t1_status", 3'd3, 32'd2);
        rd("t1_result", 3'd4, 32'h4040_0000);
        rd("t1_status_clr", 3'd3, 32'd0);

        // Byte-select write
        wr("pw0", 3'd0, 32'd0, 4'hF);
        wr("pw1", 3'd0, 32'hFFFF_FFFF, 4'b0010);
        rd("pw_opa", 3'd0, 32'h0000_FF00);

        // Timeout: ERR lands TIMEOUT+1 cycles after the start cycle
        go_and_chunks(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (255) tick();
        chk("tmo_busy", {31'd0, busy}, 32'd1);
        chk("tmo_irq_early", {31'd0, irq}, 32'd0);
        tick();
        chk("tmo_irq", {31'd0, irq}, 32'd1);
        chk("tmo_busy_off", {31'd0, busy}, 32'd0);
        tick();
        chk("tmo_irq_off", {31'd0, irq}, 32'd0);
        rd("tmo_status", 3'd3, 32'd4);

        // Out-of-order byte index
        go_and_chunks(32'h3FC0_0000, 32'h4000_0000);
        tick();
        res_bus = {1'b0, 1'b1, 2'd0, 8'h11};
        tick();
        res_bus = {1'b0, 1'b1, 2'd2, 8'hBB};
        tick();
        res_bus = 12'd0;
        chk("idx_irq", {31'd0, irq}, 32'd1);
        tick();
        rd("idx_result", 3'd4, 32'h0000_0011);
        rd("idx_status", 3'd3, 32'd4);

        // Writes while busy are acked but dropped
        wr("b_opa", 3'd0, 32'h3FC0_0000, 4'hF);
        wr("b_opb", 3'd1, 32'h4000_0000, 4'hF);
        wr("b_go", 3'd2, 32'd1, 4'hF);
        chk("b_chunk0", {9'd0, op_bus}, 32'h0004_0000);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        adr = BASE + 32'd4; dat = 32'hDEAD_BEEF;
        tick();
        chk("b_send_ack", {31'd0, ack}, 32'd1);
        chk("b_chunk1", {9'd0, op_bus}, 32'h0005_3FC0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        chk("b_chunk2", {9'd0, op_bus}, 32'h0006_0000);
        tick();
        chk("b_chunk3", {9'd0, op_bus}, 32'h0007_4000);
        tick();
        chk("b_start", {9'd0, op_bus}, 32'h0008_0000);
        tick();
        wr("b_opa_busy", 3'd0, 32'h1234_5678, 4'hF);
        wr("b_go_busy", 3'd2, 32'd1, 4'hF);
        // Strobe held through the ack cycle must not produce a second ack
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd12;
        tick();
        chk("hold_ack", {31'd0, ack}, 32'd1);
        chk("hold_status", dat_o, 32'd1);
        tick();
        chk("hold_noreack", {31'd0, ack}, 32'd0);
        chk("hold_dat0", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rd("b_opa_live", 3'd0, 32'h3FC0_0000);
        feed(32'h4040_0000);
        rd("b_result", 3'd4, 32'h4040_0000);
        rd("b_opb", 3'd1, 32'h4000_0000);

        // Reset in WAIT with an access in flight
        go_and_chunks(32'h3FC0_0000, 32'h4000_0000);
        tick();
        res_bus = {1'b0, 1'b1, 2'd0, 8'h55};
        tick();
        res_bus = 12'd0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd12;
        srst = 1'b1;
        tick();
        chk("mr_ack", {31'd0, ack}, 32'd0);
        chk("mr_dat", dat_o, 32'd0);
        chk("mr_op", {9'd0, op_bus}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_irq", {31'd0, irq}, 32'd0);
        srst = 1'b0; cyc = 1'b0; stb = 1'b0;
        tick();
        rd("mr_status", 3'd3, 32'd0);
        rd("mr_result", 3'd4, 32'd0);
        rd("mr_opa", 3'd0, 32'd0);
        go_and_chunks(32'h4040_0000, 32'h4000_0000);
        tick();
        feed(32'h40C0_0000);
        rd("mr2_status", 3'd3, 32'd2);
        rd("mr2_result", 3'd4, 32'h40C0_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
